// File: rtl/mod_addsub_seq.sv
// Limb-serial modular adder/subtractor over a fixed odd prime.
// Two chained limb units compute the raw sum/difference and its single-correction value in parallel.
module mod_addsub_seq #(
   parameter int              WIDTH   = 256,
   parameter int              LIMB_W  = 64,
   parameter logic [WIDTH-1:0] MODULUS =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
);

   localparam int NLIMBS = WIDTH / LIMB_W;
   localparam int CNT_W  = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NLIMBS - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_DONE} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_x;
   logic [WIDTH-1:0]   r_y;
   logic               r_op;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_cy1;
   logic               r_cy2;
   logic [WIDTH-1:0]   r_s;
   logic [WIDTH-1:0]   r_t;
   logic [WIDTH-1:0]   r_result;

   logic [LIMB_W-1:0]  w_xl;
   logic [LIMB_W-1:0]  w_yl;
   logic [LIMB_W-1:0]  w_pl;
   logic [LIMB_W:0]    w_sum1;
   logic [LIMB_W:0]    w_sum2;
   logic               w_use_t;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (in_valid)      w_state_nxt = S_RUN;
         S_RUN:  if (r_cnt == LAST) w_state_nxt = S_FIN;
         S_FIN:                     w_state_nxt = S_DONE;
         S_DONE: if (out_ready)     w_state_nxt = S_IDLE;
         default:                   w_state_nxt = S_IDLE;
      endcase
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign result    = r_result;

   always_comb begin
      w_xl = '0;
      w_yl = '0;
      w_pl = '0;
      for (int i = 0; i < NLIMBS; i++) begin
         if (r_cnt == CNT_W'(i)) begin
            w_xl = r_x[i*LIMB_W +: LIMB_W];
            w_yl = r_y[i*LIMB_W +: LIMB_W];
            w_pl = MODULUS[i*LIMB_W +: LIMB_W];
         end
      end
   end

   // Bit LIMB_W of each unit is the carry (add) or borrow (subtract) into the next limb.
   always_comb begin
      if (!r_op) begin
         w_sum1 = {1'b0, w_xl} + {1'b0, w_yl} + {{LIMB_W{1'b0}}, r_cy1};
         w_sum2 = {1'b0, w_sum1[LIMB_W-1:0]} - {1'b0, w_pl} - {{LIMB_W{1'b0}}, r_cy2};
      end else begin
         w_sum1 = {1'b0, w_xl} - {1'b0, w_yl} - {{LIMB_W{1'b0}}, r_cy1};
         w_sum2 = {1'b0, w_sum1[LIMB_W-1:0]} + {1'b0, w_pl} + {{LIMB_W{1'b0}}, r_cy2};
      end
   end

   // Add: take s-P when the sum overflowed or s-P did not borrow. Sub: add P back only on borrow.
   assign w_use_t = r_op ? r_cy1 : (r_cy1 | ~r_cy2);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x      <= '0;
         r_y      <= '0;
         r_op     <= 1'b0;
         r_cnt    <= '0;
         r_cy1    <= 1'b0;
         r_cy2    <= 1'b0;
         r_s      <= '0;
         r_t      <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_x   <= x;
                  r_y   <= y;
                  r_op  <= op;
                  r_cnt <= '0;
                  r_cy1 <= 1'b0;
                  r_cy2 <= 1'b0;
               end
            end
            S_RUN: begin
               r_cy1 <= w_sum1[LIMB_W];
               r_cy2 <= w_sum2[LIMB_W];
               for (int i = 0; i < NLIMBS; i++) begin
                  if (r_cnt == CNT_W'(i)) begin
                     r_s[i*LIMB_W +: LIMB_W] <= w_sum1[LIMB_W-1:0];
                     r_t[i*LIMB_W +: LIMB_W] <= w_sum2[LIMB_W-1:0];
                  end
               end
               r_cnt <= r_cnt + CNT_W'(1);
            end
            S_FIN: r_result <= w_use_t ? r_t : r_s;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mod_addsub_seq.sv
// Randomized and directed checks of mod_addsub_seq at LIMB_W = 64, 32 and 256 against a mod-P model.
module tb_mod_addsub_seq;

   localparam logic [255:0] P =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
   localparam int NV = 1000;

   logic         clk;
   logic         reset;
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic         op_a      [3];
   logic [255:0] x_a       [3];
   logic [255:0] y_a       [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [255:0] res_a     [3];

   int n_total = 0;
   int n_bad   = 0;
   int exp_lat [3] = '{5, 9, 2};

   mod_addsub_seq #(.WIDTH(256), .LIMB_W(64), .MODULUS(P)) u_dut64 (
      .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .op(op_a[0]), .x(x_a[0]), .y(y_a[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .result(res_a[0]));

   mod_addsub_seq #(.WIDTH(256), .LIMB_W(32), .MODULUS(P)) u_dut32 (
      .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .op(op_a[1]), .x(x_a[1]), .y(y_a[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .result(res_a[1]));

   mod_addsub_seq #(.WIDTH(256), .LIMB_W(256), .MODULUS(P)) u_dut256 (
      .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .op(op_a[2]), .x(x_a[2]), .y(y_a[2]), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .result(res_a[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
      n_total++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [255:0] ref_model(input logic o, input logic [255:0] a, input logic [255:0] b);
      logic [256:0] w;
      if (!o) begin
         w = {1'b0, a} + {1'b0, b};
         if (w >= {1'b0, P}) w = w - {1'b0, P};
      end else begin
         if (a >= b) w = {1'b0, a} - {1'b0, b};
         else        w = {1'b0, a} + {1'b0, P} - {1'b0, b};
      end
      return w[255:0];
   endfunction

   function automatic logic [255:0] rand_lt_p();
      logic [255:0] v;
      case ($urandom_range(0, 7))
         0: v = P - 256'd1;
         1: v = 256'd0;
         2: v = 256'($urandom_range(0, 15));
         default: begin
            do begin
               for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
            end while (v >= P);
         end
      endcase
      return v;
   endfunction

   // Issues one op on DUT d; reports result, cycles from accept edge to out_valid,
   // and whether in_ready was ever seen high while waiting.
   task automatic run_op(input int d, input logic o, input logic [255:0] a, input logic [255:0] b,
                         input bit ack, output logic [255:0] res, output int lat, output bit rdy_hi);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready[d] && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      op_a[d] = o; x_a[d] = a; y_a[d] = b; in_valid[d] = 1'b1;
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
      x_a[d] = ~a; y_a[d] = ~b; op_a[d] = ~o;
      lat = 0;
      rdy_hi = 1'b0;
      while (!out_valid[d] && lat < 40) begin
         if (in_ready[d]) rdy_hi = 1'b1;
         @(posedge clk);
         #1;
         lat++;
      end
      if (!out_valid[d]) check("timeout", 256'(lat), 256'(exp_lat[d]));
      res = res_a[d];
      if (ack) begin
         @(negedge clk);
         out_ready[d] = 1'b1;
         @(posedge clk);
         #1;
         out_ready[d] = 1'b0;
      end
   endtask

   typedef struct {logic o; logic [255:0] a; logic [255:0] b; logic [255:0] r; string tag;} vec_t;

   initial begin
      logic [255:0] r;
      int           lat;
      bit           rh;
      vec_t         dv [6];

      for (int d = 0; d < 3; d++) begin
         in_valid[d] = 1'b0; op_a[d] = 1'b0; x_a[d] = '0; y_a[d] = '0; out_ready[d] = 1'b0;
      end
      reset = 1'b1;
      #1;
      check("rst_in_ready", 256'(in_ready[0]), 256'd1);
      check("rst_out_valid", 256'(out_valid[0]), 256'd0);
      check("rst_result", res_a[0], 256'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // limb-boundary carry
      run_op(0, 1'b0, {192'd0, 64'hFFFFFFFF_FFFFFFFF}, 256'd1, 1'b1, r, lat, rh);
      check("carry_res", r, 256'h1_0000000000000000);
      check("carry_lat", 256'(lat), 256'd5);
      check("carry_rdy_low", 256'(rh), 256'd0);

      dv[0] = '{1'b0, P - 256'd1, 256'd1,      256'd0,       "add_eq"};
      dv[1] = '{1'b0, P - 256'd1, P - 256'd1,  P - 256'd2,   "add_ovf"};
      dv[2] = '{1'b1, 256'd1,     256'd2,      P - 256'd1,   "sub_wrap"};
      dv[3] = '{1'b1, 256'd5,     256'd5,      256'd0,       "sub_zero"};
      dv[4] = '{1'b1, 256'h10,    256'h3,      256'hD,       "sub_small"};
      dv[5] = '{1'b0, 256'd0,     256'd0,      256'd0,       "add_zero"};
      for (int i = 0; i < 6; i++) begin
         run_op(0, dv[i].o, dv[i].a, dv[i].b, 1'b1, r, lat, rh);
         check(dv[i].tag, r, dv[i].r);
      end

      // backpressure
      run_op(0, 1'b0, 256'd3, 256'd4, 1'b0, r, lat, rh);
      check("bp_res", r, 256'd7);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         in_valid[0] = (c == 3);
         x_a[0] = 256'd100; y_a[0] = 256'd200;
         check("bp_hold_res", res_a[0], 256'd7);
         check("bp_hold_ov", 256'(out_valid[0]), 256'd1);
         check("bp_hold_ir", 256'(in_ready[0]), 256'd0);
      end
      @(negedge clk);
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[0] = 1'b0;
      check("bp_ack_ov", 256'(out_valid[0]), 256'd0);
      check("bp_ack_ir", 256'(in_ready[0]), 256'd1);
      repeat (6) @(negedge clk);
      check("bp_no_ghost", 256'(out_valid[0]), 256'd0);

      // reset during second RUN cycle
      @(negedge clk);
      op_a[0] = 1'b0; x_a[0] = 256'd9; y_a[0] = 256'd9; in_valid[0] = 1'b1;
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_ov", 256'(out_valid[0]), 256'd0);
      check("mid_rst_res", res_a[0], 256'd0);
      check("mid_rst_ir", 256'(in_ready[0]), 256'd1);
      @(negedge clk);
      reset = 1'b0;
      run_op(0, 1'b0, 256'd1, 256'd1, 1'b1, r, lat, rh);
      check("post_rst_res", r, 256'd2);
      check("post_rst_lat", 256'(lat), 256'd5);

      // random sweep over all three limb widths
      for (int d = 0; d < 3; d++) begin
         int nv;
         nv = (d == 0) ? 200 : NV;
         for (int i = 0; i < nv; i++) begin
            logic [255:0] a, b;
            logic         o;
            a = rand_lt_p();
            b = rand_lt_p();
            o = 1'($urandom_range(0, 1));
            run_op(d, o, a, b, 1'b1, r, lat, rh);
            check($sformatf("rand_res_%0d", d), r, ref_model(o, a, b));
            check($sformatf("rand_lat_%0d", d), 256'(lat), 256'(exp_lat[d]));
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
